// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the sub-word load/store sequencer.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Halves need an even address, words need lane 0; the reserved size is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = lane[0];
      SIZE_W:  mis = (lane != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Lane steering for sub-word accesses: extends a loaded lane and merges store lanes.
module byte_lane_merge
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane(s) and extend them to a full word.
  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  load_val = {{24{sgn & byte_sel[7]}}, byte_sel};
      SIZE_H:  load_val = {{16{sgn & half_sel[15]}}, half_sel};
      default: load_val = word;
    endcase
  end

  // Overlay the store data onto the old word; full words replace it outright.
  always_comb begin
    store_word = word;
    case (size)
      SIZE_B: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      SIZE_H: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sub-word load/store sequencer between the datapath and a word-wide data memory.
//
//  state | meaning
//  IDLE  | waiting for req_valid; classifies the request on acceptance
//  RD    | mem_read high; captures the memory word (load data or RMW base)
//  WR    | mem_write high; full word or merged sub-word store
//  DONE  | done pulse, rdata valid for loads
//  ERR   | done + misalign pulse, memory untouched
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          misalign,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t      state, state_nxt;
  logic [31:0] rd_buf;
  logic [31:0] lane_word;
  logic [31:0] load_val;
  logic [31:0] store_word;

  // In RD the extract path looks straight at the memory so rdata is ready on DONE entry.
  assign lane_word = (state == ST_RD) ? mem_rdata : rd_buf;

  byte_lane_merge u_merge (
    .word       (lane_word),
    .lane       (req_addr[1:0]),
    .size       (req_size),
    .sgn        (req_signed),
    .wdata      (req_wdata),
    .load_val   (load_val),
    .store_word (store_word)
  );

  assign mem_addr  = {req_addr[AW-1:2], 2'b00};
  assign mem_wdata = store_word;
  assign done      = (state == ST_DONE) || (state == ST_ERR);
  assign misalign  = (state == ST_ERR);

  // State register plus the read buffer and the load result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rd_buf <= '0;
      rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RD) begin
        rd_buf <= mem_rdata;
        if (!req_write) rdata <= load_val;
      end
    end
  end

  // Next-state and memory strobes; everything is forced quiet while reset is held.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          stall = 1'b1;
          if (is_misaligned(req_size, req_addr[1:0])) state_nxt = ST_ERR;
          else if (req_write && (req_size == SIZE_W))  state_nxt = ST_WR;
          else                                         state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        mem_read  = 1'b1;
        stall     = 1'b1;
        state_nxt = req_write ? ST_WR : ST_DONE;
      end
      ST_WR: begin
        mem_write = 1'b1;
        stall     = 1'b1;
        state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!rst) begin
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-level reference memory, monitor pops on done.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall, done, misalign, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference memory as plain bytes; the DUT-side memory is a word array.
  logic [7:0]  ref_b [0:255];
  logic [31:0] dmem  [0:63];
  logic        load_mem = 1'b1;

  assign mem_rdata = dmem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++)
        dmem[i] <= {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
    end else if (mem_write) begin
      dmem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        mis;
    logic [31:0] rdata;
    logic [31:0] wword;
    int          lat;
    int          nrd;
    int          nwr;
    int          issue;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  // Monitor: protocol checks every cycle, scoreboard pop on every done pulse.
  int   n_st = 0, n_rd = 0, n_wr = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      n_st = 0; n_rd = 0; n_wr = 0; prev_done = 1'b0;
    end else begin
      if (mem_read || mem_write) check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (stall) n_st++;
      if (mem_read) n_rd++;
      if (mem_write) begin
        n_wr++;
        if (q.size() > 0) check("mem_wdata", mem_wdata, q[0].wword);
      end
      if (prev_done) check("done_one_cycle", {31'd0, done}, 32'd0);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("misalign", {31'd0, misalign}, {31'd0, e.mis});
          check("rdata", rdata, e.rdata);
          check("latency", cyc - e.issue, e.lat);
          check("stall_cycles", n_st, e.lat);
          check("read_count", n_rd, e.nrd);
          check("write_count", n_wr, e.nwr);
        end
        n_st = 0; n_rd = 0; n_wr = 0;
      end
      prev_done = done;
    end
  end

  task automatic wait_done();
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      if (q.size() > 0) void'(q.pop_front());
    end
  endtask

  // Issue one request in an IDLE cycle; the model is updated from byte-level rules.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [7:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] v;
    int          nb;
    e.mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    e.wword = '0;
    e.nrd = 0;
    e.nwr = 0;
    if (e.mis) begin
      e.lat = 1;
    end else if (!w) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[a + 8'(i)];
      if (sg && nb == 1) v = 32'(signed'(v[7:0]));
      if (sg && nb == 2) v = 32'(signed'(v[15:0]));
      last_rdata = v;
      e.lat = 2; e.nrd = 1;
    end else begin
      for (int i = 0; i < nb; i++) ref_b[a + 8'(i)] = wd[8*i +: 8];
      e.wword = word_at(a);
      e.lat = (nb == 4) ? 2 : 3;
      e.nrd = (nb == 4) ? 0 : 1;
      e.nwr = 1;
    end
    e.rdata = last_rdata;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = {24'd0, a}; req_wdata = wd;
    e.issue = cyc;
    q.push_back(e);
    wait_done();
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom);
    ref_b[8'h10] = 8'hEF; ref_b[8'h11] = 8'hBE; ref_b[8'h12] = 8'hAD; ref_b[8'h13] = 8'hDE;

    // Reset with a pending request: strobes and stall must stay low.
    req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h10;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; load_mem = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("reset_rdata", rdata, 32'd0);
    check("reset_misalign", {31'd0, misalign}, 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0);          // LW    -> DEADBEEF
    idle(1);
    do_req(1'b0, 2'b00, 1'b1, 8'h11, 32'd0);          // LB    -> FFFFFFBE
    idle(2);
    do_req(1'b0, 2'b00, 1'b0, 8'h11, 32'd0);          // LBU   -> 000000BE
    do_req(1'b0, 2'b01, 1'b1, 8'h12, 32'd0);          // LH    -> FFFFDEAD
    idle(1);
    do_req(1'b1, 2'b00, 1'b0, 8'h12, 32'h0000_0055);  // SB    -> DE55BEEF
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0);
    idle(1);
    do_req(1'b1, 2'b01, 1'b0, 8'h11, 32'h0000_AAAA);  // SH misaligned
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0);
    idle(1);
    do_req(1'b1, 2'b10, 1'b0, 8'h20, 32'h1234_5678);  // SW then LW back-to-back
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'd0);
    idle(1);

    // Reset during the WR cycle of an SB must abort the write.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h0000_0099;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (mem_write) seen = 1'b1;
      end
      check("abort_reached_wr", {31'd0, seen}, 32'd1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_rdata = '0;
    @(negedge clk);
    check("abort_rdata", rdata, 32'd0);
    check("abort_idle_stall", {31'd0, stall}, 32'd0);
    check("abort_idle_done", {31'd0, done}, 32'd0);
    check("abort_mem_word", dmem[8], word_at(8'h20));

    for (int n = 0; n < 250; n++) begin
      logic [1:0] sz;
      logic [7:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(2);

    for (int i = 0; i < 64; i++) check("final_mem", dmem[i], word_at(8'(4 * i)));
    check("queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
